// File: rtl/bcd_counter_bank.sv
// Bank of independent BCD counters fed by a shared prescaled tick or per-channel event pulses.
// Optional load port: define BCD_COUNTER_BANK_LOAD_EN to add load/load_value.
module bcd_counter_chan #(
   parameter int                   DIGITS  = 2,
   parameter logic [DIGITS*4-1:0] MAX_BCD = '0
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                tick_i,
   input  logic                tick_mode_i,
   input  logic                event_pulse_i,
   input  logic                toggle_pulse_i,
   input  logic                clear_i,
   input  logic                down_i,
`ifdef BCD_COUNTER_BANK_LOAD_EN
   input  logic                load_i,
   input  logic [DIGITS*4-1:0] load_value_i,
`endif
   output logic                running_o,
   output logic [DIGITS*4-1:0] count_o,
   output logic                wrap_pulse_o
);
   typedef enum logic {RUN = 1'b0, PAUSE = 1'b1} state_t;

   state_t                 state_q, state_d;
   logic [DIGITS-1:0][3:0] cnt_q, cnt_d, inc, dec;
   logic                   wrap_q, wrap_d;
   logic                   en, carry, borrow;

   // Ripple carry/borrow across digits; only used when value is away from the wrap points.
   always_comb begin
      inc    = cnt_q;
      dec    = cnt_q;
      carry  = 1'b1;
      borrow = 1'b1;
      for (int d = 0; d < DIGITS; d++) begin
         if (carry) begin
            if (cnt_q[d] == 4'd9) inc[d] = 4'd0;
            else begin
               inc[d] = cnt_q[d] + 4'd1;
               carry  = 1'b0;
            end
         end
         if (borrow) begin
            if (cnt_q[d] == 4'd0) dec[d] = 4'd9;
            else begin
               dec[d] = cnt_q[d] - 4'd1;
               borrow = 1'b0;
            end
         end
      end
   end

`ifdef BCD_COUNTER_BANK_LOAD_EN
   logic load_ok;
   // With every nibble a legal digit, an unsigned compare of the packed word is a numeric compare.
   always_comb begin
      load_ok = (load_value_i <= MAX_BCD);
      for (int d = 0; d < DIGITS; d++)
         if (load_value_i[4*d +: 4] > 4'd9) load_ok = 1'b0;
   end
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      wrap_d  = 1'b0;
      en      = (state_q == RUN) && (tick_mode_i ? tick_i : event_pulse_i);
      if (toggle_pulse_i) state_d = (state_q == RUN) ? PAUSE : RUN;
      if (clear_i) cnt_d = '0;
`ifdef BCD_COUNTER_BANK_LOAD_EN
      else if (load_i) begin
         if (load_ok) cnt_d = load_value_i;
      end
`endif
      else if (en) begin
         if (down_i) begin
            if (cnt_q == '0) begin
               cnt_d  = MAX_BCD;
               wrap_d = 1'b1;
            end else cnt_d = dec;
         end else begin
            if (cnt_q == MAX_BCD) begin
               cnt_d  = '0;
               wrap_d = 1'b1;
            end else cnt_d = inc;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= RUN;
         cnt_q   <= '0;
         wrap_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         wrap_q  <= wrap_d;
      end
   end

   assign running_o    = (state_q == RUN);
   assign count_o      = cnt_q;
   assign wrap_pulse_o = wrap_q;
endmodule

module bcd_counter_bank #(
   parameter int CHANNELS    = 4,
   parameter int DIGITS      = 2,
   parameter int MAX_VALUE   = 30,
   parameter int TICK_CYCLES = 10_000_000
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [CHANNELS-1:0]          tick_mode,
   input  logic [CHANNELS-1:0]          event_pulse,
   input  logic [CHANNELS-1:0]          toggle_pulse,
   input  logic [CHANNELS-1:0]          clear,
   input  logic [CHANNELS-1:0]          down,
`ifdef BCD_COUNTER_BANK_LOAD_EN
   input  logic [CHANNELS-1:0]          load,
   input  logic [CHANNELS*DIGITS*4-1:0] load_value,
`endif
   output logic [CHANNELS-1:0]          running,
   output logic [CHANNELS*DIGITS*4-1:0] count_bcd,
   output logic [CHANNELS-1:0]          wrap_pulse,
   output logic                         tick
);
   localparam int W  = DIGITS * 4;
   localparam int PW = $clog2(TICK_CYCLES);

   function automatic logic [W-1:0] to_bcd(input int v);
      logic [W-1:0] r;
      int           t;
      r = '0;
      t = v;
      for (int d = 0; d < DIGITS; d++) begin
         r[4*d +: 4] = 4'(t % 10);
         t           = t / 10;
      end
      return r;
   endfunction

   localparam logic [W-1:0]  MAX_BCD    = to_bcd(MAX_VALUE);
   localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_CYCLES - 1);

   if (MAX_VALUE < 0 || MAX_VALUE >= 10**DIGITS) begin : g_bad_max
      $error("MAX_VALUE must be below 10**DIGITS");
   end
   if (TICK_CYCLES < 2) begin : g_bad_tick
      $error("TICK_CYCLES must be at least 2");
   end

   logic [PW-1:0] presc_q, presc_d;

   assign tick    = (presc_q == PRESC_LAST);
   assign presc_d = tick ? '0 : presc_q + PW'(1);

   always_ff @(posedge clk) begin
      if (!rst_n) presc_q <= '0;
      else        presc_q <= presc_d;
   end

   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      bcd_counter_chan #(.DIGITS(DIGITS), .MAX_BCD(MAX_BCD)) u_chan (
         .clk           (clk),
         .rst_n         (rst_n),
         .tick_i        (tick),
         .tick_mode_i   (tick_mode[i]),
         .event_pulse_i (event_pulse[i]),
         .toggle_pulse_i(toggle_pulse[i]),
         .clear_i       (clear[i]),
         .down_i        (down[i]),
`ifdef BCD_COUNTER_BANK_LOAD_EN
         .load_i        (load[i]),
         .load_value_i  (load_value[i*W +: W]),
`endif
         .running_o     (running[i]),
         .count_o       (count_bcd[i*W +: W]),
         .wrap_pulse_o  (wrap_pulse[i])
      );
   end
endmodule
